// File: rtl/pck_control.sv
// rtl/pck_control.sv - decode control enumerations
package pck_control;

    typedef enum logic [2:0] {
        INSTR_R,
        INSTR_I,
        INSTR_S,
        INSTR_B,
        INSTR_U,
        INSTR_J,
        INSTR_IU,
        INSTR_IUCSR
    } instr_type_e;

    typedef enum logic [1:0] {
        EMPTY,
        ONE,
        TWO
    } imm_buf_state_e;

endpackage

// File: rtl/pck_isa.sv
// rtl/pck_isa.sv - RISC-V base instruction field layout
package pck_isa;

    typedef struct packed {
        logic [6:0] funct7;
        logic [4:0] rs2;
        logic [4:0] rs1;
        logic [2:0] funct3;
        logic [4:0] rd;
        logic [6:0] opcode;
    } isa_instr_t;

endpackage

// File: rtl/pck_sext.sv
// rtl/pck_sext.sv - width-generic sign extension helper
package pck_sext;

    localparam int unsigned max_xlen = 64;

    // Sign-extends the low n bits of value (1 <= n <= 32) to max_xlen; callers truncate to their xlen.
    function automatic logic [max_xlen-1:0] sext_n(input logic [31:0] value, input int unsigned n);
        logic [max_xlen-1:0] r;
        logic [4:0]          msb;
        msb = 5'(n - 1);
        r   = '0;
        for (int unsigned i = 0; i < 32; i++) begin
            r[i] = (i < n) ? value[i] : value[msb];
        end
        for (int unsigned i = 32; i < max_xlen; i++) begin
            r[i] = value[msb];
        end
        return r;
    endfunction

endpackage

// File: rtl/cpu_imm_dec_xlen.sv
// rtl/cpu_imm_dec_xlen.sv - combinational immediate decoder
module cpu_imm_dec_xlen
    import pck_isa::*;
    import pck_control::*;
    import pck_sext::*;
#(
    parameter int p_xlen       = 32,
    parameter bit p_branch_imm = 1'b0
) (
    input  isa_instr_t        instr,
    input  instr_type_e       instr_type,
    output logic [p_xlen-1:0] imm
);

    logic [31:0]         raw;
    logic [max_xlen-1:0] imm_wide;
    logic                unused_bits;

    assign raw = instr;

    always_comb begin
        imm_wide = '0;
        case (instr_type)
            INSTR_B:     imm_wide = sext_n(32'({raw[31], raw[7], raw[30:25], raw[11:8], 1'b0}), 13);
            INSTR_J:     imm_wide = sext_n(32'({raw[31], raw[19:12], raw[20], raw[30:21], 1'b0}), 21);
            INSTR_I:     imm_wide = sext_n(32'(raw[31:20]), 12);
            INSTR_S:     if (!p_branch_imm) imm_wide = sext_n(32'({raw[31:25], raw[11:7]}), 12);
            INSTR_U:     if (!p_branch_imm) imm_wide = sext_n({raw[31:12], 12'b0}, 32);
            INSTR_IU:    if (!p_branch_imm) imm_wide = max_xlen'(raw[31:20]);
            INSTR_IUCSR: if (!p_branch_imm) imm_wide = max_xlen'(raw[19:15]);
            default:     imm_wide = '0;
        endcase
    end

    assign imm = imm_wide[p_xlen-1:0];

    // Opcode and high bits beyond p_xlen are intentionally dropped.
    assign unused_bits = ^{raw[6:0], imm_wide};

endmodule

// File: rtl/cpu_imm_unit.sv
// rtl/cpu_imm_unit.sv - registered handshaked immediate stage with skid buffer
module cpu_imm_unit
    import pck_isa::*;
    import pck_control::*;
#(
    parameter int p_xlen       = 32,
    parameter bit p_branch_imm = 1'b0,
    parameter int p_tag_width  = 32,
    parameter bit p_skid       = 1'b1
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_flush,
    input  logic                   i_valid,
    output logic                   o_ready,
    input  isa_instr_t             i_instr,
    input  instr_type_e            i_instr_type,
    input  logic [p_tag_width-1:0] i_tag,
    output logic                   o_valid,
    input  logic                   i_ready,
    output logic [p_xlen-1:0]      o_imm,
    output logic [p_tag_width-1:0] o_tag,
    output logic                   o_imm_zero
);

    logic [p_xlen-1:0]      dec_imm;
    logic                   dec_zero;
    imm_buf_state_e         state;
    logic                   ready_q;
    logic [p_xlen-1:0]      skid_imm;
    logic [p_tag_width-1:0] skid_tag;
    logic                   skid_zero;
    logic                   accept;
    logic                   deliver;

    cpu_imm_dec_xlen #(
        .p_xlen       (p_xlen),
        .p_branch_imm (p_branch_imm)
    ) u_dec (
        .instr      (i_instr),
        .instr_type (i_instr_type),
        .imm        (dec_imm)
    );

    assign dec_zero = (dec_imm == '0);
    assign o_ready  = p_skid ? ready_q : (!i_rst && (state == EMPTY || i_ready));
    assign accept   = i_valid && o_ready;
    assign deliver  = o_valid && i_ready;

    // Without a skid buffer o_ready in ONE implies i_ready, so ONE never advances to TWO.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= EMPTY;
            ready_q    <= 1'b0;
            o_valid    <= 1'b0;
            o_imm      <= '0;
            o_tag      <= '0;
            o_imm_zero <= 1'b1;
            skid_imm   <= '0;
            skid_tag   <= '0;
            skid_zero  <= 1'b1;
        end else if (i_flush) begin
            state   <= EMPTY;
            ready_q <= 1'b1;
            o_valid <= 1'b0;
        end else begin
            case (state)
                EMPTY: begin
                    ready_q <= 1'b1;
                    if (accept) begin
                        o_imm      <= dec_imm;
                        o_tag      <= i_tag;
                        o_imm_zero <= dec_zero;
                        o_valid    <= 1'b1;
                        state      <= ONE;
                    end
                end
                ONE: begin
                    if (accept && !deliver) begin
                        skid_imm  <= dec_imm;
                        skid_tag  <= i_tag;
                        skid_zero <= dec_zero;
                        ready_q   <= 1'b0;
                        state     <= TWO;
                    end else if (accept) begin
                        o_imm      <= dec_imm;
                        o_tag      <= i_tag;
                        o_imm_zero <= dec_zero;
                    end else if (deliver) begin
                        o_valid <= 1'b0;
                        state   <= EMPTY;
                    end
                end
                TWO: begin
                    if (deliver) begin
                        o_imm      <= skid_imm;
                        o_tag      <= skid_tag;
                        o_imm_zero <= skid_zero;
                        ready_q    <= 1'b1;
                        state      <= ONE;
                    end
                end
                default: begin
                    state   <= EMPTY;
                    o_valid <= 1'b0;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_imm_unit.sv
// tb/tb_cpu_imm_unit.sv - self-checking bench for cpu_imm_unit
module tb_cpu_imm_unit;
    import pck_isa::*;
    import pck_control::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, flush, i_valid, i_ready;
    isa_instr_t  instr;
    instr_type_e ty;
    logic [31:0] tag;

    logic        rdy_a, ov_a, zero_a;
    logic [31:0] imm_a, tag_a;
    logic        rdy_b, ov_b, zero_b;
    logic [63:0] imm_b;
    logic [31:0] tag_b;
    logic        rdy_c, ov_c, zero_c;
    logic [31:0] imm_c, tag_c;

    cpu_imm_unit #(.p_xlen(32), .p_branch_imm(1'b0), .p_tag_width(32), .p_skid(1'b1)) dut_a (
        .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_valid(i_valid), .o_ready(rdy_a),
        .i_instr(instr), .i_instr_type(ty), .i_tag(tag), .o_valid(ov_a), .i_ready(i_ready),
        .o_imm(imm_a), .o_tag(tag_a), .o_imm_zero(zero_a));

    cpu_imm_unit #(.p_xlen(64), .p_branch_imm(1'b0), .p_tag_width(32), .p_skid(1'b0)) dut_b (
        .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_valid(i_valid), .o_ready(rdy_b),
        .i_instr(instr), .i_instr_type(ty), .i_tag(tag), .o_valid(ov_b), .i_ready(i_ready),
        .o_imm(imm_b), .o_tag(tag_b), .o_imm_zero(zero_b));

    cpu_imm_unit #(.p_xlen(32), .p_branch_imm(1'b1), .p_tag_width(32), .p_skid(1'b1)) dut_c (
        .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_valid(i_valid), .o_ready(rdy_c),
        .i_instr(instr), .i_instr_type(ty), .i_tag(tag), .o_valid(ov_c), .i_ready(i_ready),
        .o_imm(imm_c), .o_tag(tag_c), .o_imm_zero(zero_c));

    typedef struct {
        logic [31:0] raw;
        instr_type_e ty;
        logic [31:0] e32;
        logic [63:0] e64;
        logic [31:0] ebr;
    } vec_t;

    typedef struct packed {
        logic [63:0] imm;
        logic [31:0] tag;
        logic        zero;
    } exp_t;

    vec_t        vecs [10];
    logic [63:0] exp_in [3];
    exp_t        q0[$], q1[$], q2[$];
    int          passed = 0;
    int          total  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s: got %h, need %h", name, act, req);
    endtask

    function automatic exp_t mk(input int k);
        exp_t e;
        e.imm  = exp_in[k];
        e.tag  = tag;
        e.zero = (exp_in[k] == 64'd0);
        return e;
    endfunction

    task automatic sb_check(input int k, input logic [63:0] imm, input logic [31:0] tg, input logic z);
        exp_t e;
        bit   ok;
        e  = '0;
        ok = 1'b0;
        case (k)
            0: begin ok = (q0.size() != 0); if (ok) e = q0.pop_front(); end
            1: begin ok = (q1.size() != 0); if (ok) e = q1.pop_front(); end
            default: begin ok = (q2.size() != 0); if (ok) e = q2.pop_front(); end
        endcase
        chk($sformatf("sb_expected_output_%0d", k), 64'(ok), 64'd1);
        if (ok) begin
            chk($sformatf("sb_imm_%0d_tag%0h", k, e.tag), imm, e.imm);
            chk($sformatf("sb_tag_%0d", k), 64'(tg), 64'(e.tag));
            chk($sformatf("sb_zero_%0d_tag%0h", k, e.tag), 64'(z), 64'(e.zero));
        end
    endtask

    // Scoreboard: deliveries are popped first, then this cycle's acceptances are pushed.
    always @(negedge clk) begin
        if (ov_a && i_ready) sb_check(0, {32'b0, imm_a}, tag_a, zero_a);
        if (ov_b && i_ready) sb_check(1, imm_b, tag_b, zero_b);
        if (ov_c && i_ready) sb_check(2, {32'b0, imm_c}, tag_c, zero_c);
        if (rst || flush) begin
            q0.delete();
            q1.delete();
            q2.delete();
        end else begin
            if (i_valid && rdy_a) q0.push_back(mk(0));
            if (i_valid && rdy_b) q1.push_back(mk(1));
            if (i_valid && rdy_c) q2.push_back(mk(2));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_vec(input int idx, input logic [31:0] tg);
        instr     = vecs[idx].raw;
        ty        = vecs[idx].ty;
        tag       = tg;
        exp_in[0] = {32'b0, vecs[idx].e32};
        exp_in[1] = vecs[idx].e64;
        exp_in[2] = {32'b0, vecs[idx].ebr};
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, need finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{32'hFE000EE3, INSTR_B,     32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 32'hFFFFFFFC};
        vecs[1] = '{32'h800000B7, INSTR_U,     32'h80000000, 64'hFFFFFFFF80000000, 32'h00000000};
        vecs[2] = '{32'h305FD073, INSTR_IUCSR, 32'h0000001F, 64'h000000000000001F, 32'h00000000};
        vecs[3] = '{32'hFFF00093, INSTR_I,     32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 32'hFFFFFFFF};
        vecs[4] = '{32'hFFF00093, INSTR_IU,    32'h00000FFF, 64'h0000000000000FFF, 32'h00000000};
        vecs[5] = '{32'hFE000C23, INSTR_S,     32'hFFFFFFF8, 64'hFFFFFFFFFFFFFFF8, 32'h00000000};
        vecs[6] = '{32'h001000EF, INSTR_J,     32'h00000800, 64'h0000000000000800, 32'h00000800};
        vecs[7] = '{32'h002081B3, INSTR_R,     32'h00000000, 64'h0000000000000000, 32'h00000000};
        vecs[8] = '{32'h12345037, INSTR_U,     32'h12345000, 64'h0000000012345000, 32'h00000000};
        vecs[9] = '{32'hFFFFF06F, INSTR_J,     32'hFFFFFFFE, 64'hFFFFFFFFFFFFFFFE, 32'hFFFFFFFE};

        rst = 1'b1; flush = 1'b0; i_valid = 1'b0; i_ready = 1'b0;
        instr = '0; ty = INSTR_R; tag = '0;
        exp_in[0] = '0; exp_in[1] = '0; exp_in[2] = '0;

        step();
        chk("rst_valid", 64'(ov_a), 64'd0);
        chk("rst_imm", 64'(imm_a), 64'd0);
        chk("rst_tag", 64'(tag_a), 64'd0);
        chk("rst_zero", 64'(zero_a), 64'd1);
        chk("rst_ready", 64'(rdy_a), 64'd0);
        chk("rst_ready_skid0", 64'(rdy_b), 64'd0);
        step();
        rst = 1'b0;
        step();
        chk("ready_after_rst", 64'(rdy_a), 64'd1);

        i_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            set_vec(i, 32'h100 + i);
            i_valid = 1'b1;
            step();
            if (i == 0) begin
                chk("lat_valid", 64'(ov_a), 64'd1);
                chk("lat_imm32", 64'(imm_a), 64'hFFFFFFFC);
                chk("lat_tag", 64'(tag_a), 64'h100);
                chk("lat_imm64", imm_b, 64'hFFFFFFFFFFFFFFFC);
            end
            chk("stream_ready", 64'(rdy_a), 64'd1);
        end
        i_valid = 1'b0;
        step();
        step();

        i_ready = 1'b0;
        set_vec(3, 32'hA);
        i_valid = 1'b1;
        step();
        chk("skid0_ready_stall", 64'(rdy_b), 64'd0);
        set_vec(4, 32'hB);
        step();
        chk("bp_ready_low", 64'(rdy_a), 64'd0);
        chk("bp_head_tag", 64'(tag_a), 64'hA);
        set_vec(5, 32'hC);
        step();
        chk("bp_hold_valid", 64'(ov_a), 64'd1);
        chk("bp_hold_tag", 64'(tag_a), 64'hA);
        chk("bp_hold_imm", 64'(imm_a), 64'hFFFFFFFF);
        i_ready = 1'b1;
        #1;
        chk("skid0_ready_comb", 64'(rdy_b), 64'd1);
        step();
        chk("bp_out_b", 64'(tag_a), 64'hB);
        chk("bp_ready_back", 64'(rdy_a), 64'd1);
        step();
        chk("bp_out_c", 64'(tag_a), 64'hC);
        i_valid = 1'b0;
        step();
        chk("bp_drained", 64'(ov_a), 64'd0);

        i_ready = 1'b0;
        set_vec(6, 32'hD);
        i_valid = 1'b1;
        step();
        set_vec(7, 32'hE);
        step();
        chk("flush_pre_two", 64'(rdy_a), 64'd0);
        flush = 1'b1;
        set_vec(8, 32'hF);
        step();
        chk("flush_valid", 64'(ov_a), 64'd0);
        chk("flush_ready", 64'(rdy_a), 64'd1);
        flush = 1'b0;
        i_valid = 1'b0;
        i_ready = 1'b1;
        repeat (3) step();
        chk("flush_no_leak", 64'(ov_a), 64'd0);

        i_ready = 1'b0;
        set_vec(9, 32'h77);
        i_valid = 1'b1;
        step();
        i_valid = 1'b0;
        chk("midrst_held", 64'(ov_a), 64'd1);
        rst = 1'b1;
        step();
        chk("midrst_valid", 64'(ov_a), 64'd0);
        chk("midrst_imm", 64'(imm_a), 64'd0);
        chk("midrst_tag", 64'(tag_a), 64'd0);
        chk("midrst_zero", 64'(zero_a), 64'd1);
        chk("midrst_ready", 64'(rdy_a), 64'd0);
        rst = 1'b0;
        step();
        chk("midrst_ready_after", 64'(rdy_a), 64'd1);
        chk("midrst_valid_after", 64'(ov_a), 64'd0);

        i_ready = 1'b1;
        repeat (2) step();
        chk("sb_left_a", 64'(q0.size()), 64'd0);
        chk("sb_left_b", 64'(q1.size()), 64'd0);
        chk("sb_left_c", 64'(q2.size()), 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
